fetch_unit: RTL and testbench

Instruction fetch stage, directly upstream of the decode/register-file stage. Holds the program counter and issues a request/acknowledge read to instruction memory when the stage controller selects the fetch stage. Delivers the captured 32-bit instruction (ir_o) and its address (pc_o) to decode. Accepts branch/jump redirects from execute and flags fetch faults.

---
 rtl/fetch_unit.sv | 183 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Holds the program counter and issues one instruction-memory read each time
// the stage controller selects the fetch stage. The captured word and its
// address go to decode. Branch/jump redirects come from execute. A memory
// timeout raises a sticky fault.
//
// Optional build macro: PILLAR_FETCH_MISALIGN_EN
//   defined   : a redirect target with nonzero low bits raises the sticky
//               misalign_o flag and parks the unit in FAULT.
//   undefined : misalign_o is tied low and the low target bits are cleared.
//
// Memory handshake: imem_req_o rises together with a stable imem_addr_o. Both
// hold until a cycle in which imem_ack_i is high. That cycle completes the
// transfer, and imem_data_i is sampled only in that cycle. An ack seen while
// the unit is not in REQ is ignored.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h00000000,
    parameter logic [2:0]  FETCH_STAGE = 3'd0,
    parameter int          TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  stage_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] ir_o,
    output logic [31:0] pc_o,
    output logic        ir_valid_o,
    output logic        done_o,
    output logic        fault_o,
    output logic        misalign_o
);

    localparam int             CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [31:0]    NOP      = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    // state_q is the observable FSM state for checkers
    state_t        state_q, state_d;
    logic [31:0]   next_pc_q;
    logic [CW-1:0] cnt_q;
    logic          discard_q;     // a redirect arrived mid-request; drop its response

    logic [31:0]   redirect_tgt;
    logic          bad_redirect;
    logic          fetch_go;
    logic          capture;
    logic          refetch;
    logic          timeout_hit;

    assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};

`ifdef PILLAR_FETCH_MISALIGN_EN
    assign bad_redirect = redirect_i && (redirect_pc_i[1:0] != 2'b00) && (state_q != FAULT);
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc_i[1:0];
    assign bad_redirect    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-cycle event strobes
    always_comb begin
        state_d     = state_q;
        fetch_go    = 1'b0;
        capture     = 1'b0;
        refetch     = 1'b0;
        timeout_hit = 1'b0;
        if (bad_redirect) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stage_i == FETCH_STAGE) begin
                        state_d  = REQ;
                        fetch_go = 1'b1;
                    end
                end
                REQ: begin
                    if (imem_ack_i) begin
                        if (discard_q) begin
                            refetch = 1'b1;
                        end else begin
                            capture = 1'b1;
                            state_d = DONE;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_hit = 1'b1;
                        state_d     = FAULT;
                    end
                end
                DONE: begin
                    if (stage_i != FETCH_STAGE) begin
                        state_d = IDLE;
                    end
                end
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath: PC, request port, instruction register and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            next_pc_q   <= RESET_PC;
            pc_o        <= RESET_PC;
            ir_o        <= NOP;
            ir_valid_o  <= 1'b0;
            imem_req_o  <= 1'b0;
            imem_addr_o <= 32'h00000000;
            done_o      <= 1'b0;
            fault_o     <= 1'b0;
            misalign_o  <= 1'b0;
            cnt_q       <= '0;
            discard_q   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (bad_redirect) begin
                misalign_o <= 1'b1;
                imem_req_o <= 1'b0;
                discard_q  <= 1'b0;
            end else begin
                if (redirect_i && (state_q == IDLE || state_q == DONE)) begin
                    next_pc_q <= redirect_tgt;
                end
                if (fetch_go) begin
                    imem_addr_o <= redirect_i ? redirect_tgt : next_pc_q;
                    imem_req_o  <= 1'b1;
                    ir_valid_o  <= 1'b0;
                    cnt_q       <= '0;
                    discard_q   <= 1'b0;
                end
                if (state_q == REQ) begin
                    if (capture) begin
                        ir_o       <= imem_data_i;
                        pc_o       <= imem_addr_o;
                        next_pc_q  <= redirect_i ? redirect_tgt : imem_addr_o + 32'd4;
                        ir_valid_o <= 1'b1;
                        done_o     <= 1'b1;
                        imem_req_o <= 1'b0;
                    end else if (refetch) begin
                        imem_addr_o <= redirect_i ? redirect_tgt : next_pc_q;
                        if (redirect_i) begin
                            next_pc_q <= redirect_tgt;
                        end
                        cnt_q     <= '0;
                        discard_q <= 1'b0;
                    end else if (timeout_hit) begin
                        imem_req_o <= 1'b0;
                        fault_o    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (redirect_i) begin
                            next_pc_q <= redirect_tgt;
                            discard_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit.
// The driver plays the stage controller, the execute redirect source and the
// instruction memory. A reference program counter decides which address each
// request must carry and which (pc, word) pair each capture must deliver. A
// monitor pops those pairs whenever done_o pulses.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h00000000;
    localparam logic [2:0]  FETCH    = 3'd0;
    localparam int          TO       = 16;
    localparam logic [31:0] NOP      = 32'h00000013;

    // clock / reset
    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic [2:0]  stage;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        ir_valid;
    logic        done;
    logic        fault;
    logic        misalign;

    fetch_unit #(
        .RESET_PC    (RESET_PC),
        .FETCH_STAGE (FETCH),
        .TIMEOUT     (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stage_i       (stage),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_req_o    (imem_req),
        .imem_ack_i    (imem_ack),
        .imem_data_i   (imem_data),
        .ir_o          (ir),
        .pc_o          (pc),
        .ir_valid_o    (ir_valid),
        .done_o        (done),
        .fault_o       (fault),
        .misalign_o    (misalign)
    );

    // scoreboard state
    logic [63:0] exp_q[$];   // {pc, instruction} of each capture still to come
    logic [31:0] model_pc;   // address the next request must carry
    logic [31:0] last_pc;    // pc of the most recent expected capture
    logic [63:0] mon_e;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: every done_o pulse must match the oldest expected capture
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: pc_o %h ir_o %h, no capture expected", pc, ir);
            end else begin
                mon_e = exp_q.pop_front();
                chk("cap_pc", pc, mon_e[63:32]);
                chk("cap_ir", ir, mon_e[31:0]);
                chk("cap_valid", {31'd0, ir_valid}, 32'd1);
            end
        end
    end

    // watchdog
    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // driver tasks -- all start and end at a falling edge
    task automatic check_reset_state();
        chk("rst_pc", pc, RESET_PC);
        chk("rst_ir", ir, NOP);
        chk("rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        stage     = 3'd1;
        redirect  = 1'b0;
        imem_ack  = 1'b1;            // an ack during reset must be ignored
        imem_data = 32'hBAD0BAD0;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        imem_ack  = 1'b0;
        exp_q.delete();
        model_pc  = RESET_PC;
        last_pc   = RESET_PC;
        check_reset_state();
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic redirect_idle(input logic [31:0] tgt);
        redirect    = 1'b1;
        redirect_pc = tgt;
        @(negedge clk);
        redirect    = 1'b0;
        model_pc    = tgt & 32'hFFFFFFFC;
    endtask

    task automatic start_fetch(output bit ok);
        stage = FETCH;
        wait_req(ok);
        chk("req_seen", {31'd0, ok}, 32'd1);
        if (ok) begin
            chk("req_addr", imem_addr, model_pc);
            chk("req_valid_low", {31'd0, ir_valid}, 32'd0);
        end
    endtask

    task automatic finish_fetch(input int lat, input logic [31:0] data,
                                input bit redir, input logic [31:0] tgt);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, model_pc);
        end
        exp_q.push_back({model_pc, data});
        last_pc   = model_pc;
        model_pc  = model_pc + 32'd4;
        imem_ack  = 1'b1;
        imem_data = data;
        if (redir) begin
            redirect    = 1'b1;
            redirect_pc = tgt;
            model_pc    = tgt;
        end
        @(negedge clk);
        imem_ack  = 1'b0;
        redirect  = 1'b0;
        imem_data = $urandom;
        stage     = 3'($urandom_range(1, 7));
        @(negedge clk);
        chk("valid_held", {31'd0, ir_valid}, 32'd1);
        chk("req_dropped", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic fetch_one(input int lat, input logic [31:0] data,
                             input bit redir, input logic [31:0] tgt);
        bit ok;
        start_fetch(ok);
        if (ok) begin
            finish_fetch(lat, data, redir, tgt);
        end else begin
            stage = 3'd1;
        end
    endtask

    // stimulus
    initial begin
        bit ok;
        int cnt;
        int stray;
        stage       = 3'd1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ack    = 1'b0;
        imem_data   = 32'd0;
        reset       = 1'b1;
        @(negedge clk);
        reset_dut();

        // first fetch with a two-cycle memory, then the next sequential one
        fetch_one(2, 32'h00500093, 1'b0, 32'd0);
        fetch_one(1, $urandom, 1'b0, 32'd0);

        // back-to-back zero-wait fetches from reset: pc 0, 4, 8, 12
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            fetch_one(0, $urandom, 1'b0, 32'd0);
        end

        // randomized traffic: latencies, idle redirects, redirect with ack, stray acks
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                redirect_idle({$urandom_range(0, 32'h3FFF), 2'b00});
            end else if (r == 1) begin
                imem_ack  = 1'b1;
                imem_data = $urandom;
                @(negedge clk);
                imem_ack  = 1'b0;
            end
            fetch_one($urandom_range(0, 4), $urandom, ($urandom_range(0, 5) == 0),
                      {$urandom_range(0, 32'h3FFF), 2'b00});
        end

        // redirect during a request: in-flight response is dropped, refetch at target
        start_fetch(ok);
        if (ok) begin
            redirect    = 1'b1;
            redirect_pc = 32'h00000100;
            @(negedge clk);
            redirect    = 1'b0;
            repeat (2) @(negedge clk);
            chk("rd_req_held", {31'd0, imem_req}, 32'd1);
            imem_ack  = 1'b1;
            imem_data = 32'hDEADBEEF;
            @(negedge clk);
            imem_ack  = 1'b0;
            chk("rd_readdr", imem_addr, 32'h00000100);
            chk("rd_rereq", {31'd0, imem_req}, 32'd1);
            chk("rd_pc_kept", pc, last_pc);
            chk("rd_valid_low", {31'd0, ir_valid}, 32'd0);
            model_pc = 32'h00000100;
            finish_fetch(1, $urandom, 1'b0, 32'd0);
        end else begin
            stage = 3'd1;
        end

        // address wrap at the top of memory
        redirect_idle(32'hFFFFFFFC);
        fetch_one($urandom_range(0, 3), $urandom, 1'b0, 32'd0);
        fetch_one($urandom_range(0, 3), $urandom, 1'b0, 32'd0);

        // misaligned redirect target
        redirect_idle(32'h00000102);
`ifdef PILLAR_FETCH_MISALIGN_EN
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_fault_low", {31'd0, fault}, 32'd0);
        stage = FETCH;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (imem_req) stray++;
        end
        chk("mis_no_req", stray, 32'd0);
        reset_dut();
`else
        chk("mis_flag_tied", {31'd0, misalign}, 32'd0);
        fetch_one(1, $urandom, 1'b0, 32'd0);
`endif

        // reset in the middle of a request
        start_fetch(ok);
        reset_dut();

        // memory never answers: timeout fault
        start_fetch(ok);
        cnt = 0;
        for (int i = 0; i < 40 && imem_req; i++) begin
            cnt++;
            @(negedge clk);
        end
        chk("to_req_cycles", cnt, TO);
        chk("to_fault", {31'd0, fault}, 32'd1);
        chk("to_req_low", {31'd0, imem_req}, 32'd0);
        chk("to_misalign_low", {31'd0, misalign}, 32'd0);
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            stage = (i % 2 == 0) ? 3'd2 : FETCH;
            @(negedge clk);
            if (imem_req) stray++;
        end
        chk("to_no_req", stray, 32'd0);
        chk("to_fault_sticky", {31'd0, fault}, 32'd1);
        stage = 3'd1;
        reset_dut();
        fetch_one(1, $urandom, 1'b0, 32'd0);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
